// File: rtl/exe_stage_unit.sv
// Execute stage: builds Val2, runs the ALU with NZCV generation, resolves branches,
// and holds the architectural status register plus the EX/MEM pipeline register.
module exe_stage_unit #(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic [WORD_LENGTH-1:0] pc_in,
    input  logic [WORD_LENGTH-1:0] val_rn_in,
    input  logic [WORD_LENGTH-1:0] val_rm_in,
    input  logic [23:0]            signed_immediate_in,
    input  logic [11:0]            shift_operand_in,
    input  logic                   is_immediate_in,
    input  logic                   status_write_enable_in,
    input  logic [3:0]             execute_command_in,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic                   wb_enable_in,
    input  logic                   is_branch_in,
    input  logic [3:0]             dest_reg_in,
    output logic [3:0]             status_reg_out,
    output logic                   branch_taken,
    output logic                   flush,
    output logic [WORD_LENGTH-1:0] branch_address,
    output logic [WORD_LENGTH-1:0] alu_result_out,
    output logic [WORD_LENGTH-1:0] store_data_out,
    output logic [3:0]             dest_reg_out,
    output logic                   mem_read_out,
    output logic                   mem_write_out,
    output logic                   wb_enable_out
);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;

    localparam int MSB = WORD_LENGTH - 1;

    logic                   c_flag;
    logic                   v_flag;
    logic [WORD_LENGTH-1:0] val2;
    logic [WORD_LENGTH-1:0] imm_word;
    logic [WORD_LENGTH-1:0] rot_src;
    logic [4:0]             rot_amount;
    logic [2*WORD_LENGTH-1:0] rot_pair;
    logic [4:0]             shift_amount;
    logic [1:0]             shift_type;
    logic                   is_mem_op;

    logic                   is_sub;
    logic                   add_cin;
    logic [WORD_LENGTH-1:0] add_b;
    logic [WORD_LENGTH:0]   sum_ext;
    logic                   sum_overflow;

    logic [WORD_LENGTH-1:0] alu_result;
    logic [3:0]             flags_next;

    assign c_flag = status_reg_out[1];
    assign v_flag = status_reg_out[0];

    // Branch resolution stays combinational so IF/ID sees it in the same cycle, even under freeze.
    assign branch_taken   = is_branch_in;
    assign flush          = is_branch_in;
    assign branch_address = pc_in + {{(WORD_LENGTH-26){signed_immediate_in[23]}},
                                     signed_immediate_in, 2'b00};

    assign is_mem_op    = mem_read_in | mem_write_in;
    assign shift_amount = shift_operand_in[11:7];
    assign shift_type   = shift_operand_in[6:5];
    assign imm_word     = {{(WORD_LENGTH-8){1'b0}}, shift_operand_in[7:0]};

    // Both the immediate rotator and the register ROR share one doubled-word right shifter.
    always_comb begin
        rot_src    = val_rm_in;
        rot_amount = shift_amount;
        if (is_immediate_in) begin
            rot_src    = imm_word;
            rot_amount = {shift_operand_in[11:8], 1'b0};
        end
    end

    assign rot_pair = {rot_src, rot_src} >> rot_amount;

    always_comb begin
        val2 = val_rm_in;
        if (is_mem_op) begin
            val2 = {{(WORD_LENGTH-12){1'b0}}, shift_operand_in};
        end else if (is_immediate_in) begin
            val2 = rot_pair[WORD_LENGTH-1:0];
        end else begin
            case (shift_type)
                2'b00:   val2 = val_rm_in << shift_amount;
                2'b01:   val2 = val_rm_in >> shift_amount;
                2'b10:   val2 = WORD_LENGTH'($signed(val_rm_in) >>> shift_amount);
                default: val2 = rot_pair[WORD_LENGTH-1:0];
            endcase
        end
    end

    // Subtraction is rn + ~val2 + cin, so one adder serves all four arithmetic commands.
    always_comb begin
        is_sub  = (execute_command_in == CMD_SUB) || (execute_command_in == CMD_SBC);
        add_b   = is_sub ? ~val2 : val2;
        case (execute_command_in)
            CMD_ADC: add_cin = c_flag;
            CMD_SUB: add_cin = 1'b1;
            CMD_SBC: add_cin = c_flag;
            default: add_cin = 1'b0;
        endcase
    end

    assign sum_ext      = {1'b0, val_rn_in} + {1'b0, add_b} + {{WORD_LENGTH{1'b0}}, add_cin};
    assign sum_overflow = (val_rn_in[MSB] == add_b[MSB]) && (sum_ext[MSB] != val_rn_in[MSB]);

    always_comb begin
        alu_result = '0;
        flags_next = status_reg_out;
        case (execute_command_in)
            CMD_MOV: alu_result = val2;
            CMD_MVN: alu_result = ~val2;
            CMD_AND: alu_result = val_rn_in & val2;
            CMD_ORR: alu_result = val_rn_in | val2;
            CMD_EOR: alu_result = val_rn_in ^ val2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: alu_result = sum_ext[WORD_LENGTH-1:0];
            default: alu_result = '0;
        endcase
        case (execute_command_in)
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC:
                flags_next = {alu_result[MSB], (alu_result == '0), sum_ext[WORD_LENGTH], sum_overflow};
            CMD_MOV, CMD_MVN, CMD_AND, CMD_ORR, CMD_EOR:
                flags_next = {alu_result[MSB], (alu_result == '0), c_flag, v_flag};
            default:
                flags_next = status_reg_out;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            status_reg_out <= 4'b0000;
            alu_result_out <= '0;
            store_data_out <= '0;
            dest_reg_out   <= 4'd0;
            mem_read_out   <= 1'b0;
            mem_write_out  <= 1'b0;
            wb_enable_out  <= 1'b0;
        end else if (!freeze) begin
            if (status_write_enable_in) begin
                status_reg_out <= flags_next;
            end
            alu_result_out <= alu_result;
            store_data_out <= val_rm_in;
            dest_reg_out   <= dest_reg_in;
            mem_read_out   <= mem_read_in;
            mem_write_out  <= mem_write_in;
            wb_enable_out  <= wb_enable_in;
        end
    end

endmodule

// File: tb/tb_exe_stage_unit.sv
// Directed bench for exe_stage_unit: each task drives one scenario and checks the
// registered and combinational outputs against hand-computed values.
module tb_exe_stage_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic [31:0] pc_in;
    logic [31:0] val_rn_in;
    logic [31:0] val_rm_in;
    logic [23:0] signed_immediate_in;
    logic [11:0] shift_operand_in;
    logic        is_immediate_in;
    logic        status_write_enable_in;
    logic [3:0]  execute_command_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        wb_enable_in;
    logic        is_branch_in;
    logic [3:0]  dest_reg_in;
    logic [3:0]  status_reg_out;
    logic        branch_taken;
    logic        flush;
    logic [31:0] branch_address;
    logic [31:0] alu_result_out;
    logic [31:0] store_data_out;
    logic [3:0]  dest_reg_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic        wb_enable_out;

    int n_cmp;
    int n_err;
    logic [31:0] exp_q[$];

    exe_stage_unit #(.WORD_LENGTH(32)) dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .pc_in(pc_in), .val_rn_in(val_rn_in), .val_rm_in(val_rm_in),
        .signed_immediate_in(signed_immediate_in), .shift_operand_in(shift_operand_in),
        .is_immediate_in(is_immediate_in), .status_write_enable_in(status_write_enable_in),
        .execute_command_in(execute_command_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .wb_enable_in(wb_enable_in), .is_branch_in(is_branch_in),
        .dest_reg_in(dest_reg_in), .status_reg_out(status_reg_out), .branch_taken(branch_taken),
        .flush(flush), .branch_address(branch_address), .alu_result_out(alu_result_out),
        .store_data_out(store_data_out), .dest_reg_out(dest_reg_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out), .wb_enable_out(wb_enable_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze = 0; pc_in = 0; val_rn_in = 0; val_rm_in = 0; signed_immediate_in = 0;
        shift_operand_in = 0; is_immediate_in = 0; status_write_enable_in = 0;
        execute_command_in = 0; mem_read_in = 0; mem_write_in = 0; wb_enable_in = 0;
        is_branch_in = 0; dest_reg_in = 0;
    endtask

    task automatic drive(input logic [3:0] cmd, input logic [31:0] rn, input logic [31:0] rm,
                         input logic imm_bit, input logic [11:0] shop, input logic s);
        execute_command_in = cmd; val_rn_in = rn; val_rm_in = rm;
        is_immediate_in = imm_bit; shift_operand_in = shop; status_write_enable_in = s;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        #1 rst = 1'b0;
        #2;
        n_cmp++; if (alu_result_out !== 32'h0) begin n_err++; $display("FAIL reset_alu: got %h want %h", alu_result_out, 32'h0); end
        n_cmp++; if (status_reg_out !== 4'b0000) begin n_err++; $display("FAIL reset_status: got %b want %b", status_reg_out, 4'b0000); end
        n_cmp++; if ({store_data_out, dest_reg_out, mem_read_out, mem_write_out, wb_enable_out} !== 39'h0) begin
            n_err++; $display("FAIL reset_ctrl: got %h/%h/%b%b%b want zeros", store_data_out, dest_reg_out, mem_read_out, mem_write_out, wb_enable_out); end
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_add_flags();
        idle_inputs();
        drive(4'b0010, 32'h7FFF_FFFF, 32'hDEAD_BEEF, 1'b1, 12'h001, 1'b1);
        dest_reg_in = 4'd4; wb_enable_in = 1'b1;
        tick();
        n_cmp++; if (alu_result_out !== 32'h8000_0000) begin n_err++; $display("FAIL add_result: got %h want %h", alu_result_out, 32'h8000_0000); end
        n_cmp++; if (status_reg_out !== 4'b1001) begin n_err++; $display("FAIL add_status: got %b want %b", status_reg_out, 4'b1001); end
        n_cmp++; if (store_data_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL add_store: got %h want %h", store_data_out, 32'hDEAD_BEEF); end
        n_cmp++; if ({dest_reg_out, wb_enable_out} !== 5'b0100_1) begin n_err++; $display("FAIL add_dest_wb: got %h/%b want 4/1", dest_reg_out, wb_enable_out); end
    endtask

    task automatic test_sub_adc();
        idle_inputs();
        drive(4'b0100, 32'd5, 32'd0, 1'b1, 12'h005, 1'b1);
        tick();
        n_cmp++; if (alu_result_out !== 32'h0) begin n_err++; $display("FAIL sub_result: got %h want %h", alu_result_out, 32'h0); end
        n_cmp++; if (status_reg_out !== 4'b0110) begin n_err++; $display("FAIL sub_status: got %b want %b", status_reg_out, 4'b0110); end
        drive(4'b0011, 32'd1, 32'd0, 1'b1, 12'h001, 1'b1);
        tick();
        n_cmp++; if (alu_result_out !== 32'd3) begin n_err++; $display("FAIL adc_result: got %h want %h", alu_result_out, 32'd3); end
        n_cmp++; if (status_reg_out !== 4'b0000) begin n_err++; $display("FAIL adc_status: got %b want %b", status_reg_out, 4'b0000); end
    endtask

    task automatic test_logic_and_misc();
        idle_inputs();
        // C is 0 here, so SBC subtracts an extra 1: 10 - 3 - 1 = 6 with no borrow.
        drive(4'b0101, 32'd10, 32'd0, 1'b1, 12'h003, 1'b1);
        tick();
        n_cmp++; if (alu_result_out !== 32'd6) begin n_err++; $display("FAIL sbc_result: got %h want %h", alu_result_out, 32'd6); end
        n_cmp++; if (status_reg_out !== 4'b0010) begin n_err++; $display("FAIL sbc_status: got %b want %b", status_reg_out, 4'b0010); end
        drive(4'b1111, 32'd5, 32'd0, 1'b1, 12'h001, 1'b1);
        tick();
        n_cmp++; if (alu_result_out !== 32'h0) begin n_err++; $display("FAIL invalid_result: got %h want %h", alu_result_out, 32'h0); end
        n_cmp++; if (status_reg_out !== 4'b0010) begin n_err++; $display("FAIL invalid_status: got %b want %b", status_reg_out, 4'b0010); end
        drive(4'b0001, 32'd0, 32'd0, 1'b1, 12'h000, 1'b0);
        tick();
        n_cmp++; if (status_reg_out !== 4'b0010) begin n_err++; $display("FAIL mov_nos_status: got %b want %b", status_reg_out, 4'b0010); end
        drive(4'b0110, 32'h0000_F0F0, 32'd0, 1'b1, 12'h00F, 1'b1);
        tick();
        n_cmp++; if ({alu_result_out, status_reg_out} !== {32'h0, 4'b0110}) begin n_err++; $display("FAIL and_res_status: got %h/%b want 0/0110", alu_result_out, status_reg_out); end
        drive(4'b0111, 32'h8000_0000, 32'd0, 1'b1, 12'h001, 1'b1);
        tick();
        n_cmp++; if ({alu_result_out, status_reg_out} !== {32'h8000_0001, 4'b1010}) begin n_err++; $display("FAIL orr_res_status: got %h/%b want 80000001/1010", alu_result_out, status_reg_out); end
        drive(4'b1000, 32'h0000_00FF, 32'd0, 1'b1, 12'h0FF, 1'b0);
        tick();
        n_cmp++; if (alu_result_out !== 32'h0) begin n_err++; $display("FAIL eor_result: got %h want %h", alu_result_out, 32'h0); end
        drive(4'b1001, 32'd0, 32'd0, 1'b1, 12'h000, 1'b1);
        tick();
        n_cmp++; if ({alu_result_out, status_reg_out} !== {32'hFFFF_FFFF, 4'b1010}) begin n_err++; $display("FAIL mvn_res_status: got %h/%b want ffffffff/1010", alu_result_out, status_reg_out); end
    endtask

    task automatic test_shifts();
        logic [31:0] rm_tab  [7] = '{32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_000F, 32'h1234_5678, 32'h0, 32'h0000_0002};
        logic [11:0] sh_tab  [7] = '{12'h240, 12'h200, 12'h220, 12'h260, 12'h060, 12'h4FF, 12'h080};
        logic        imm_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic [3:0]  cmd_tab [7] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        logic [31:0] exp_tab [7] = '{32'hF800_0000, 32'h0000_0010, 32'h0800_0000, 32'hF000_0000,
                                     32'h1234_5678, 32'hFF00_0000, 32'h0000_0005};
        idle_inputs();
        for (int i = 0; i < 7; i++) begin
            drive(cmd_tab[i], 32'd1, rm_tab[i], imm_tab[i], sh_tab[i], 1'b0);
            tick();
            n_cmp++; if (alu_result_out !== exp_tab[i]) begin n_err++; $display("FAIL shift_%0d: got %h want %h", i, alu_result_out, exp_tab[i]); end
        end
    endtask

    task automatic test_memory();
        idle_inputs();
        // The I bit is set on purpose: a memory op must still use the raw 12-bit offset.
        drive(4'b0010, 32'h0000_1000, 32'hCAFE_F00D, 1'b1, 12'hFFF, 1'b0);
        mem_read_in = 1'b1; dest_reg_in = 4'd7; wb_enable_in = 1'b1;
        tick();
        n_cmp++; if (alu_result_out !== 32'h0000_1FFF) begin n_err++; $display("FAIL ldr_addr: got %h want %h", alu_result_out, 32'h0000_1FFF); end
        n_cmp++; if ({mem_read_out, mem_write_out, wb_enable_out, dest_reg_out} !== 7'b1_0_1_0111) begin
            n_err++; $display("FAIL ldr_ctrl: got %b%b%b/%h want 101/7", mem_read_out, mem_write_out, wb_enable_out, dest_reg_out); end
        drive(4'b0010, 32'h0000_2000, 32'h1357_9BDF, 1'b0, 12'h004, 1'b0);
        mem_read_in = 1'b0; mem_write_in = 1'b1; wb_enable_in = 1'b0;
        tick();
        n_cmp++; if ({alu_result_out, store_data_out} !== {32'h0000_2004, 32'h1357_9BDF}) begin
            n_err++; $display("FAIL str_addr_data: got %h/%h want 00002004/13579bdf", alu_result_out, store_data_out); end
        n_cmp++; if ({mem_read_out, mem_write_out, wb_enable_out} !== 3'b010) begin
            n_err++; $display("FAIL str_ctrl: got %b%b%b want 010", mem_read_out, mem_write_out, wb_enable_out); end
    endtask

    task automatic test_branch();
        idle_inputs();
        drive(4'b0010, 32'd0, 32'd0, 1'b1, 12'h000, 1'b1);
        tick();
        n_cmp++; if (status_reg_out !== 4'b0100) begin n_err++; $display("FAIL pre_branch_status: got %b want %b", status_reg_out, 4'b0100); end
        drive(4'b0010, 32'h7FFF_FFFF, 32'd0, 1'b1, 12'h001, 1'b0);
        pc_in = 32'h0000_0100; signed_immediate_in = 24'hFFFFFE; is_branch_in = 1'b1;
        #1;
        n_cmp++; if (branch_address !== 32'h0000_00F8) begin n_err++; $display("FAIL branch_neg: got %h want %h", branch_address, 32'h0000_00F8); end
        n_cmp++; if ({flush, branch_taken} !== 2'b11) begin n_err++; $display("FAIL branch_flush: got %b%b want 11", flush, branch_taken); end
        tick();
        n_cmp++; if (status_reg_out !== 4'b0100) begin n_err++; $display("FAIL branch_nos_status: got %b want %b", status_reg_out, 4'b0100); end
        signed_immediate_in = 24'h000010;
        #1;
        n_cmp++; if (branch_address !== 32'h0000_0140) begin n_err++; $display("FAIL branch_pos: got %h want %h", branch_address, 32'h0000_0140); end
        pc_in = 32'hFFFF_FFFC; signed_immediate_in = 24'h000001;
        #1;
        n_cmp++; if (branch_address !== 32'h0000_0000) begin n_err++; $display("FAIL branch_wrap: got %h want %h", branch_address, 32'h0000_0000); end
        is_branch_in = 1'b0;
        #1;
        n_cmp++; if ({flush, branch_taken} !== 2'b00) begin n_err++; $display("FAIL branch_clear: got %b%b want 00", flush, branch_taken); end
    endtask

    task automatic test_freeze();
        idle_inputs();
        drive(4'b0010, 32'd2, 32'h1111_1111, 1'b1, 12'h003, 1'b1);
        dest_reg_in = 4'd3; wb_enable_in = 1'b1;
        tick();
        n_cmp++; if ({alu_result_out, status_reg_out} !== {32'd5, 4'b0000}) begin n_err++; $display("FAIL pre_freeze: got %h/%b want 5/0000", alu_result_out, status_reg_out); end
        freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(4'b0100, 32'(i), 32'h2222_0000 + 32'(i), 1'b1, 12'(i + 1), 1'b1);
            dest_reg_in = 4'(i + 8); mem_write_in = 1'b1; is_branch_in = i[0];
            tick();
            n_cmp++; if ({alu_result_out, status_reg_out, dest_reg_out, mem_write_out} !== {32'd5, 4'b0000, 4'd3, 1'b0}) begin
                n_err++; $display("FAIL freeze_hold_%0d: got %h/%b/%h/%b want 5/0000/3/0", i, alu_result_out, status_reg_out, dest_reg_out, mem_write_out); end
            n_cmp++; if (flush !== i[0]) begin n_err++; $display("FAIL freeze_flush_%0d: got %b want %b", i, flush, i[0]); end
        end
        freeze = 1'b0; is_branch_in = 1'b0; mem_write_in = 1'b0;
        drive(4'b0100, 32'd0, 32'h3333_3333, 1'b1, 12'h001, 1'b1);
        dest_reg_in = 4'd9;
        tick();
        n_cmp++; if ({alu_result_out, status_reg_out, dest_reg_out} !== {32'hFFFF_FFFF, 4'b1000, 4'd9}) begin
            n_err++; $display("FAIL freeze_release: got %h/%b/%h want ffffffff/1000/9", alu_result_out, status_reg_out, dest_reg_out); end
        n_cmp++; if (store_data_out !== 32'h3333_3333) begin n_err++; $display("FAIL freeze_release_store: got %h want %h", store_data_out, 32'h3333_3333); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] want;
        idle_inputs();
        exp_q.delete();
        for (int i = 1; i <= 6; i++) begin
            drive(4'b0010, 32'(i * 16), 32'd0, 1'b1, 12'(i), 1'b0);
            exp_q.push_back(32'(i * 17));
            tick();
            want = exp_q.pop_front();
            n_cmp++; if (alu_result_out !== want) begin n_err++; $display("FAIL b2b_%0d: got %h want %h", i, alu_result_out, want); end
        end
    endtask

    task automatic test_reset_midstream();
        idle_inputs();
        drive(4'b0010, 32'h8000_0000, 32'h4444_4444, 1'b1, 12'h001, 1'b1);
        wb_enable_in = 1'b1; dest_reg_in = 4'd5;
        tick();
        n_cmp++; if ({alu_result_out, status_reg_out} !== {32'h8000_0001, 4'b1000}) begin n_err++; $display("FAIL pre_reset: got %h/%b want 80000001/1000", alu_result_out, status_reg_out); end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if ({alu_result_out, status_reg_out, store_data_out, dest_reg_out, wb_enable_out} !== 73'h0) begin
            n_err++; $display("FAIL async_reset: got %h/%b/%h/%h/%b want zeros", alu_result_out, status_reg_out, store_data_out, dest_reg_out, wb_enable_out); end
        tick();
        n_cmp++; if (alu_result_out !== 32'h0) begin n_err++; $display("FAIL reset_held: got %h want %h", alu_result_out, 32'h0); end
        @(negedge clk) rst = 1'b1;
        tick();
        n_cmp++; if ({alu_result_out, status_reg_out, dest_reg_out} !== {32'h8000_0001, 4'b1000, 4'd5}) begin
            n_err++; $display("FAIL first_capture: got %h/%b/%h want 80000001/1000/5", alu_result_out, status_reg_out, dest_reg_out); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_add_flags();
        test_sub_adc();
        test_logic_and_misc();
        test_shifts();
        test_memory();
        test_branch();
        test_freeze();
        test_back_to_back();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
